// File: rtl/ece298a_8_bit_cpu_top_if.sv
// Tiny Tapeout tile pin bundle for the ECE298A 8-bit CPU.
// The harness/testbench drives through master; the CPU tile is the slave.
interface ece298a_8_bit_cpu_top_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/ece298a_8_bit_cpu_top.sv
// SAP-1 style 8-bit accumulator CPU with 16-byte RAM, 5 steps per instruction.
// Optional macro CPU_DEBUG_EN: ui_in[5] selects a {halted,C,Z,0,PC} view on uo_out.
module ece298a_8_bit_cpu_top (
    input  logic                      clk,
    input  logic                      rst_n,
    ece298a_8_bit_cpu_top_if.slave    tt
);
    localparam int unsigned RAM_DEPTH = 16;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [7:0] ram [RAM_DEPTH];

    logic [2:0] step,    step_nxt;
    logic [3:0] pc,      pc_nxt;
    logic [3:0] mar,     mar_nxt;
    logic [7:0] ir,      ir_nxt;
    logic [7:0] a_reg,   a_nxt;
    logic [7:0] b_reg,   b_nxt;
    logic [7:0] out_reg, out_nxt;
    logic       c_flag,  c_nxt;
    logic       z_flag,  z_nxt;
    logic       halted,  halted_nxt;

    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [8:0] alu_sum;
    logic       prog_mode;

    assign prog_mode = tt.ui_in[7];

    // State register for the step sequencer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= T0;
            pc      <= 4'h0;
            mar     <= 4'h0;
            ir      <= 8'h00;
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            out_reg <= 8'h00;
            c_flag  <= 1'b0;
            z_flag  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            step    <= step_nxt;
            pc      <= pc_nxt;
            mar     <= mar_nxt;
            ir      <= ir_nxt;
            a_reg   <= a_nxt;
            b_reg   <= b_nxt;
            out_reg <= out_nxt;
            c_flag  <= c_nxt;
            z_flag  <= z_nxt;
            halted  <= halted_nxt;
        end
    end

    // Next-state and microsequence decode; PROG mode overrides everything.
    always_comb begin
        step_nxt   = step;
        pc_nxt     = pc;
        mar_nxt    = mar;
        ir_nxt     = ir;
        a_nxt      = a_reg;
        b_nxt      = b_reg;
        out_nxt    = out_reg;
        c_nxt      = c_flag;
        z_nxt      = z_flag;
        halted_nxt = halted;
        ram_we     = 1'b0;
        ram_waddr  = mar;
        ram_wdata  = a_reg;
        alu_sum    = 9'h000;

        if (prog_mode) begin
            step_nxt   = T0;
            pc_nxt     = 4'h0;
            halted_nxt = 1'b0;
            ram_we     = tt.ui_in[4];
            ram_waddr  = tt.ui_in[3:0];
            ram_wdata  = tt.uio_in;
        end else if (!halted) begin
            case (step)
                T0: begin
                    mar_nxt  = pc;
                    step_nxt = T1;
                end
                T1: begin
                    ir_nxt   = ram[mar];
                    pc_nxt   = pc + 4'd1;
                    step_nxt = T2;
                end
                T2: begin
                    step_nxt = T3;
                    case (ir[7:4])
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_nxt = ir[3:0];
                        OP_LDI: a_nxt = {4'h0, ir[3:0]};
                        OP_JMP: pc_nxt = ir[3:0];
                        OP_JC:  if (c_flag) pc_nxt = ir[3:0];
                        OP_JZ:  if (z_flag) pc_nxt = ir[3:0];
                        OP_OUT: out_nxt = a_reg;
                        OP_HLT: halted_nxt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    step_nxt = T4;
                    case (ir[7:4])
                        OP_LDA:         a_nxt  = ram[mar];
                        OP_ADD, OP_SUB: b_nxt  = ram[mar];
                        OP_STA:         ram_we = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    step_nxt = T0;
                    if (ir[7:4] == OP_ADD || ir[7:4] == OP_SUB) begin
                        // Subtract as A + ~B + 1 so carry means "no borrow".
                        if (ir[7:4] == OP_ADD)
                            alu_sum = {1'b0, a_reg} + {1'b0, b_reg};
                        else
                            alu_sum = {1'b0, a_reg} + {1'b0, ~b_reg} + 9'd1;
                        a_nxt = alu_sum[7:0];
                        c_nxt = alu_sum[8];
                        z_nxt = (alu_sum[7:0] == 8'h00);
                    end
                end
                default: step_nxt = T0;
            endcase
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

`ifdef CPU_DEBUG_EN
    assign tt.uo_out = tt.ui_in[5] ? {halted, c_flag, z_flag, 1'b0, pc} : out_reg;
    logic unused_pins;
    assign unused_pins = &{1'b0, tt.ena, tt.ui_in[6]};
`else
    assign tt.uo_out = out_reg;
    logic unused_pins;
    assign unused_pins = &{1'b0, tt.ena, tt.ui_in[6:5]};
`endif

    assign tt.uio_out = 8'h00;
    assign tt.uio_oe  = 8'h00;
endmodule

// File: tb/tb_ece298a_8_bit_cpu_top.sv
// Scoreboarded bench for the 8-bit CPU tile against an instruction-level model.
module tb_ece298a_8_bit_cpu_top;
    logic clk = 1'b0;
    logic rst_n;
    ece298a_8_bit_cpu_top_if tt ();

    ece298a_8_bit_cpu_top dut (.clk(clk), .rst_n(rst_n), .tt(tt));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] img [16];
    logic [7:0] m_mem [16];
    logic [7:0] m_a, m_out;
    logic [3:0] m_pc;
    logic       m_c, m_z, m_halt;
    int         m_n;
    logic [7:0] exp_q [$];

    logic       mon_en = 1'b0;
    logic [7:0] last_out = 8'h00;

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %02h want %02h", name, got, want);
        end
    endtask

    // Monitor: every visible change of uo_out must match the next queued OUT value.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tt.uo_out !== last_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got %02h want none", tt.uo_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tt.uo_out !== e) begin
                        errors++;
                        $display("FAIL out_seq got %02h want %02h", tt.uo_out, e);
                    end
                end
            end
        end
        last_out = tt.uo_out;
    end

    // Instruction-level reference: runs the program image until HLT or a step limit.
    task automatic model_run();
        int         sum;
        logic [7:0] ir, prev;
        logic [3:0] opnd;
        for (int i = 0; i < 16; i++) m_mem[i] = img[i];
        m_a = 8'h00; m_out = 8'h00; m_pc = 4'h0;
        m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_n = 0;
        prev = 8'h00;
        exp_q.delete();
        while (!m_halt && m_n < 64) begin
            ir = m_mem[m_pc];
            opnd = ir[3:0];
            m_pc = m_pc + 4'd1;
            m_n++;
            case (ir[7:4])
                4'h1: m_a = m_mem[opnd];
                4'h2: begin
                    sum = int'(m_a) + int'(m_mem[opnd]);
                    m_c = (sum > 255);
                    m_a = 8'(sum);
                    m_z = (m_a == 8'h00);
                end
                4'h3: begin
                    m_c = (m_a >= m_mem[opnd]);
                    m_a = m_a - m_mem[opnd];
                    m_z = (m_a == 8'h00);
                end
                4'h4: m_mem[opnd] = m_a;
                4'h5: m_a = {4'h0, opnd};
                4'h6: m_pc = opnd;
                4'h7: if (m_c) m_pc = opnd;
                4'h8: if (m_z) m_pc = opnd;
                4'hE: begin
                    m_out = m_a;
                    if (m_out != prev) exp_q.push_back(m_out);
                    prev = m_out;
                end
                4'hF: m_halt = 1'b1;
                default: ;
            endcase
        end
    endtask

    // Reset the CPU, then write the whole image in PROG mode.
    task automatic load_prog();
        mon_en = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tt.ui_in  = {4'b1001, 4'(i)};
            tt.uio_in = img[i];
            @(negedge clk);
        end
        tt.ui_in = 8'h80;
        @(negedge clk);
    endtask

    task automatic check_final(input string tag);
        logic ram_ok;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d want 0", tag, exp_q.size());
        end
        check8({tag, "_out"}, tt.uo_out, m_out);
`ifdef CPU_DEBUG_EN
        tt.ui_in = 8'h20;
        #1;
        check8({tag, "_dbg"}, tt.uo_out, {1'b1, m_c, m_z, 1'b0, m_pc});
        tt.ui_in = 8'h00;
        #1;
`else
        check8({tag, "_flags"}, {6'h0, dut.c_flag, dut.z_flag}, {6'h0, m_c, m_z});
        check8({tag, "_pc_halt"}, {3'h0, dut.halted, dut.pc}, {3'h0, 1'b1, m_pc});
`endif
        ram_ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (dut.ram[i] !== m_mem[i]) ram_ok = 1'b0;
        check8({tag, "_ram_ok"}, {7'h0, ram_ok}, 8'h01);
    endtask

    // Load, run until the model's halt edge plus margin, then check end state.
    task automatic run_prog(input string tag);
        int edges;
        model_run();
        edges = 5 * (m_n - 1) + 3;
        load_prog();
        mon_en = 1'b1;
        tt.ui_in = 8'h00;
        repeat (edges + 50) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check_final(tag);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    initial begin
        logic [3:0] ops [12];
        int         tries;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};

        rst_n = 1'b0;
        tt.ena = 1'b1;
        tt.ui_in = 8'h00;
        tt.uio_in = 8'h00;
        #1;
        check8("reset_uo_out", tt.uo_out, 8'h00);
        check8("reset_uio_oe", tt.uio_oe, 8'h00);
        check8("reset_uio_out", tt.uio_out, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        // Add program with exact output timing and halt stability.
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'h1C; img[15] = 8'h0E;
        model_run();
        load_prog();
        mon_en = 1'b1;
        tt.ui_in = 8'h00;
        repeat (12) @(posedge clk);
        #1 check8("add_edge12", tt.uo_out, 8'h00);
        @(posedge clk);
        #1 check8("add_edge13", tt.uo_out, 8'h2A);
        repeat (50) @(posedge clk);
        #1 check8("add_hold50", tt.uo_out, 8'h2A);
        mon_en = 1'b0;
        check_final("add");

        // Reset during T3 of ADD, then rerun from PC=0.
        load_prog();
        tt.ui_in = 8'h00;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check8("midrst_uo_out", tt.uo_out, 8'h00);
        check8("midrst_uio_oe", tt.uio_oe, 8'h00);
        check8("midrst_a_pc", {dut.a_reg[3:0], dut.pc}, 8'h00);
        check8("midrst_ram0", dut.ram[0], 8'h1E);
        check8("midrst_ram14", dut.ram[14], 8'h1C);
        @(negedge clk) rst_n = 1'b1;
        model_run();
        mon_en = 1'b1;
        repeat (13) @(posedge clk);
        #1 check8("midrst_rerun", tt.uo_out, 8'h2A);
        repeat (20) @(posedge clk);
        #1 mon_en = 1'b0;
        check_final("midrst");

        // Subtract with borrow, then exact zero.
        clear_img();
        img[0] = 8'h55; img[1] = 8'h3F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h07;
        run_prog("sub_borrow");
        check8("sub_borrow_val", tt.uo_out, 8'hFE);
        img[15] = 8'h05;
        run_prog("sub_zero");

        // Countdown loop.
        clear_img();
        img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'hE0; img[3] = 8'h85;
        img[4] = 8'h61; img[5] = 8'hF0; img[14] = 8'h03; img[15] = 8'h01;
        run_prog("countdown");

        // STA round trip.
        clear_img();
        img[0] = 8'h59; img[1] = 8'h4D; img[2] = 8'h50;
        img[3] = 8'h1D; img[4] = 8'hE0; img[5] = 8'hF0;
        run_prog("sta");
        check8("sta_ram13", dut.ram[13], 8'h09);

        // Random programs that the model shows will halt.
        for (int p = 0; p < 20; p++) begin
            tries = 0;
            do begin
                for (int i = 0; i < 16; i++)
                    img[i] = {ops[$urandom_range(0, 11)], 4'($urandom_range(0, 15))};
                model_run();
                tries++;
            end while (!m_halt && tries < 200);
            if (m_halt) run_prog($sformatf("rand%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
